pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port stall  input  1  hazard hold; no new imem request is issued while high.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump taken, driven by the next-PC selector.
REQ-006 SHALL have port redirect_pc  input  32  redirect target word address; don't-care (may be Z) when redirect_valid=0.
REQ-007 SHALL have port imem_req_valid  output  1  instruction memory request valid.
REQ-008 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-009 SHALL have port imem_addr  output  32  request word address.
REQ-010 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, 32): instruction return.
REQ-011 SHALL have ports if_valid (output, 1), if_pc (output, 32), if_instr (output, 32) and if_ready (input, 1): fetched-instruction handshake to decode.
REQ-012 SHALL have port flush  output  1  one-cycle pulse to squash IF/ID on redirect.

Function
REQ-013 SHALL implement a state machine with states IDLE, FETCH, WAIT and DRAIN.
REQ-014 IDLE SHALL move to FETCH one cycle after rst_n is released.
REQ-015 In FETCH, imem_req_valid SHALL be high when stall=0 and the output buffer is empty or being consumed (if_valid and if_ready both high); imem_addr SHALL equal pc.
REQ-016 A FETCH request SHALL transfer when imem_req_valid and imem_req_ready are both high, and the state SHALL then move to WAIT.
REQ-017 In WAIT, imem_resp_valid SHALL load the 1-entry output buffer with if_pc=pc and if_instr=resp_data, set if_valid=1 on the next cycle, set pc to pc+1 (word addressing, wraps modulo 2^32) and return to FETCH.
REQ-018 if_valid, if_pc and if_instr SHALL hold stable until if_ready=1; stall SHALL NOT clear the buffer.
REQ-019 A redirect (redirect_valid=1) in any non-IDLE state SHALL, on the same edge, load pc with redirect_pc, clear if_valid and pulse flush for exactly one cycle.
REQ-020 A redirect in WAIT without imem_resp_valid SHALL move to DRAIN; DRAIN SHALL discard the next response and then move to FETCH.
REQ-021 A redirect in WAIT with imem_resp_valid in the same cycle SHALL discard the response and move directly to FETCH.
REQ-022 A redirect in FETCH with a simultaneous request handshake SHALL move to DRAIN, because the accepted request is stale.
REQ-023 A redirect in DRAIN SHALL update pc and stay in DRAIN.
REQ-024 Redirect SHALL take priority over stall, over the if_ready consume and over the response capture.
REQ-025 There SHALL be at most one outstanding imem request; fetch-to-if_valid latency SHALL be 2 cycles when memory responds the cycle after accept.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0 and flush=0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding request, and a response arriving after reset release SHALL be ignored until the first new request is accepted.

Configuration
REQ-028 Macro PC_FETCH_REDIRECT_CNT_EN SHALL control a redirect counter.
REQ-029 With PC_FETCH_REDIRECT_CNT_EN defined, the block SHALL add output redirect_count (16 bits), reset to 0, incremented on every flush pulse and saturating at 16'hFFFF.
REQ-030 Without PC_FETCH_REDIRECT_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Reset with RESET_PC=0, ready=1, response one cycle after accept, if_ready=1 -> imem_addr sequence 0,1,2,3; if_pc 0,1,2 with matching if_instr.
REQ-032 Hold if_ready=0 for 5 cycles with a full buffer -> no new request; if_pc/if_instr stable; on release, the next request carries pc+1.
REQ-033 redirect_valid=1, redirect_pc=32'h40 while in WAIT -> flush high 1 cycle; next response discarded; next imem_addr=32'h40.
REQ-034 Redirect coincident with imem_resp_valid -> response dropped, if_valid=0, next imem_addr=redirect_pc, no DRAIN cycle.
REQ-035 pc=32'hFFFF_FFFF fetch completes -> next imem_addr=32'h0000_0000.
REQ-036 rst_n=0 for 1 cycle while in WAIT, then response arrives -> ignored; first request after reset is to RESET_PC; with the macro defined, redirect_count=0.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request and a 1-entry output buffer to decode.
// Optional build macro PC_FETCH_REDIRECT_CNT_EN adds a saturating 16-bit redirect_count output.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    output logic        flush
`ifdef PC_FETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic        buf_valid_d;
    logic [31:0] buf_pc_d;
    logic [31:0] buf_instr_d;
    logic        flush_d;

    logic consume;
    logic req_fire;
    logic redirect;

    assign consume  = if_valid && if_ready;
    assign req_fire = imem_req_valid && imem_req_ready;
    // Redirects are only meaningful once the pipeline is running.
    assign redirect = redirect_valid && (state != IDLE);

    assign imem_req_valid = (state == FETCH) && !stall && (!if_valid || if_ready);
    assign imem_addr      = pc;

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        buf_valid_d = if_valid && !consume;
        buf_pc_d    = if_pc;
        buf_instr_d = if_instr;
        flush_d     = redirect;

        case (state)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A request accepted in the same cycle as a redirect fetches a stale address.
                if (req_fire) begin
                    state_d = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_resp_valid ? FETCH : DRAIN;
                end else if (imem_resp_valid) begin
                    state_d     = FETCH;
                    buf_valid_d = 1'b1;
                    buf_pc_d    = pc;
                    buf_instr_d = imem_resp_data;
                    pc_d        = pc + 32'd1;
                end
            end
            DRAIN: begin
                // The stale response is swallowed; leaving here avoids waiting on a reply that never comes.
                if (imem_resp_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
            flush    <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            if_valid <= buf_valid_d;
            if_pc    <= buf_pc_d;
            if_instr <= buf_instr_d;
            flush    <= flush_d;
        end
    end

`ifdef PC_FETCH_REDIRECT_CNT_EN
    // Counts flush pulses, so it lags the pulse by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_count <= 16'h0;
        end else if (flush && (redirect_count != 16'hFFFF)) begin
            redirect_count <= redirect_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: latency-programmable memory responder, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_pc_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b1;
    logic        flush;
`ifdef PC_FETCH_REDIRECT_CNT_EN
    logic [15:0] redirect_count;
`endif

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush)
`ifdef PC_FETCH_REDIRECT_CNT_EN
        , .redirect_count(redirect_count)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory responder: answers each accepted request 'lat' cycles later, whatever happened meanwhile.
    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;
    rsp_t        rq[$];
    int          cyc = 0;
    int          lat = 1;
    logic        hs_s = 1'b0;
    logic [31:0] hs_a = 32'h0;
    logic [31:0] acc_log[$];
    logic [31:0] out_pc[$];
    logic [31:0] out_in[$];

    always @(negedge clk) begin
        hs_s = imem_req_valid && imem_req_ready;
        hs_a = imem_addr;
        if (hs_s) acc_log.push_back(hs_a);
        if (if_valid && if_ready) begin
            out_pc.push_back(if_pc);
            out_in.push_back(if_instr);
        end
    end

    always @(posedge clk) begin
        rsp_t e;
        cyc++;
        if (hs_s) begin
            e.due  = cyc + lat - 1;
            e.addr = hs_a;
            rq.push_back(e);
        end
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = rq[0].addr ^ KEY;
            void'(rq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    end

    // Reference model in transaction terms: running / request outstanding / outstanding reply is stale.
    bit          started = 0;
    logic        m_run = 1'b0, m_out = 1'b0, m_stale = 1'b0, m_valid = 1'b0, m_flush = 1'b0;
    logic [31:0] m_pc = RST_PC, m_ipc = 32'h0, m_instr = 32'h0;
    logic [15:0] m_cnt = 16'h0;

    always @(posedge clk) begin
        bit req, acc, cons;
        started = 1;
        if (!rst_n) begin
            m_run = 0; m_out = 0; m_stale = 0; m_valid = 0; m_flush = 0;
            m_pc = RST_PC; m_ipc = 0; m_instr = 0; m_cnt = 0;
        end else begin
            if (m_flush && m_cnt != 16'hFFFF) m_cnt++;
            if (!m_run) begin
                m_run   = 1;
                m_flush = 0;
            end else begin
                req  = !m_out && !stall && (!m_valid || if_ready);
                acc  = req && imem_req_ready;
                cons = m_valid && if_ready;
                m_flush = redirect_valid;
                if (redirect_valid) begin
                    m_pc    = redirect_pc;
                    m_valid = 0;
                    if (m_out) begin
                        if (imem_resp_valid) begin m_out = 0; m_stale = 0; end
                        else m_stale = 1;
                    end else if (acc) begin
                        m_out = 1; m_stale = 1;
                    end
                end else begin
                    if (cons) m_valid = 0;
                    if (m_out) begin
                        if (imem_resp_valid) begin
                            if (!m_stale) begin
                                m_valid = 1; m_ipc = m_pc; m_instr = imem_resp_data; m_pc = m_pc + 1;
                            end
                            m_out = 0; m_stale = 0;
                        end
                    end else if (acc) begin
                        m_out = 1; m_stale = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic m_req;
        if (started) begin
            m_req = m_run && !m_out && !stall && (!m_valid || if_ready);
            chk("req_valid", 32'(imem_req_valid), 32'(m_req));
            if (m_req) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            chk("if_pc", if_pc, m_ipc);
            chk("if_instr", if_instr, m_instr);
            chk("flush", 32'(flush), 32'(m_flush));
`ifdef PC_FETCH_REDIRECT_CNT_EN
            chk("redirect_count", 32'(redirect_count), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(output int nt);
        int n0;
        n0 = acc_log.size();
        nt = 0;
        while (acc_log.size() == n0 && nt < 30) begin
            tick();
            nt++;
        end
        chk("accept_seen", 32'(acc_log.size() > n0), 32'd1);
    endtask

    initial begin
        int nt;
        int n0;
        logic [31:0] hp, hi;

        repeat (2) tick();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_pc", imem_addr, RST_PC);

        // Streaming fetch, memory answers one cycle after accept
        acc_log.delete(); out_pc.delete(); out_in.delete();
        rst_n = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) chk("seq_addr", acc_log[i], 32'(i));
        for (int i = 0; i < 3; i++) begin
            chk("seq_if_pc", out_pc[i], 32'(i));
            chk("seq_if_instr", out_in[i], 32'(i) ^ KEY);
        end

        // Decode back-pressure holds the buffer and blocks new requests
        if_ready = 1'b0;
        repeat (4) tick();
        hp = if_pc; hi = if_instr;
        n0 = acc_log.size();
        repeat (5) begin
            tick();
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, hp);
            chk("hold_instr", if_instr, hi);
        end
        chk("hold_no_req", 32'(acc_log.size()), 32'(n0));
        if_ready = 1'b1;
        wait_acc(nt);
        chk("hold_next_addr", acc_log[$], hp + 32'd1);

        // Redirect while waiting on memory: flush pulse, stale reply dropped
        lat = 3;
        wait_acc(nt);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; redirect_pc = $urandom;
        chk("wait_redir_flush", 32'(flush), 32'd1);
        chk("wait_redir_if_valid", 32'(if_valid), 32'd0);
        tick();
        chk("flush_one_cycle", 32'(flush), 32'd0);
        wait_acc(nt);
        chk("wait_redir_addr", acc_log[$], 32'h40);

        // Redirect coincident with the response: no drain cycle
        lat = 1;
        wait_acc(nt);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0; redirect_pc = $urandom;
        chk("coinc_flush", 32'(flush), 32'd1);
        chk("coinc_if_valid", 32'(if_valid), 32'd0);
        wait_acc(nt);
        chk("coinc_no_drain", 32'(nt), 32'd1);
        chk("coinc_addr", acc_log[$], 32'h80);

        // PC wrap at the top of the address space
        stall = 1'b1;
        repeat (4) tick();
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0; redirect_pc = $urandom;
        stall = 1'b0;
        wait_acc(nt);
        chk("wrap_first", acc_log[$], 32'hFFFF_FFFF);
        wait_acc(nt);
        chk("wrap_next", acc_log[$], 32'h0000_0000);
        chk("wrap_if_pc", out_pc[$], 32'hFFFF_FFFF);
`ifdef PC_FETCH_REDIRECT_CNT_EN
        chk("count_three", 32'(redirect_count), 32'd3);
`endif

        // Reset while a request is outstanding; its late reply must be ignored
        lat = 3;
        wait_acc(nt);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_if_valid", 32'(if_valid), 32'd0);
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_req", 32'(imem_req_valid), 32'd0);
`ifdef PC_FETCH_REDIRECT_CNT_EN
        chk("midrst_count", 32'(redirect_count), 32'd0);
`endif
        n0 = out_pc.size();
        wait_acc(nt);
        chk("midrst_addr", acc_log[$], RST_PC);
        repeat (10) tick();
        chk("midrst_delivered", 32'(out_pc.size() > n0), 32'd1);
        if (out_pc.size() > n0) begin
            chk("midrst_if_pc", out_pc[n0], RST_PC);
            chk("midrst_if_instr", out_in[n0], RST_PC ^ KEY);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
